serial_frame_receiver: RTL and testbench

- Receiving end of the single-bit serial line that the team's stimulus benches drive on `a`.
- Samples the line once per enabled clock and recognises frames of the form: start bit (1), WIDTH data bits sent LSB first, stop bit (0).
- Presents each good frame as a parallel word with a one-cycle valid pulse, and flags malformed frames.
- Sits between a serial source (bench driver or upstream serializer) and parallel consumer logic.

---
 rtl/serial_frame_receiver.sv | 102 ++++++++++
 tb/tb_serial_frame_receiver.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: deserialises start(1)/WIDTH data LSB-first/stop(0) frames into parallel words.
// Define SERIAL_FRAME_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_frame_receiver #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_en,
  input  logic             a,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam int BW = $clog2(WIDTH);
`ifdef SERIAL_FRAME_PARITY_EN
  typedef enum logic [1:0] {IDLE, DATA, STOP, PARITY} state_t;
  logic par, par_n;
`else
  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n, dout_n;
  logic [BW-1:0] bc, bc_n;
  logic [CNT_W-1:0] fc_n;
  logic dv_n, fe_n, good;
  always_comb begin
    state_n = state;
    sh_n = sh;
    bc_n = bc;
    dout_n = data_out;
    fc_n = frame_cnt;
    dv_n = 1'b0;
    fe_n = 1'b0;
`ifdef SERIAL_FRAME_PARITY_EN
    par_n = par;
    good = ~a & ~(^{sh, par});
`else
    good = ~a;
`endif
    if (bit_en) begin
      case (state)
        IDLE: begin
          state_n = a ? DATA : IDLE;
          bc_n = '0;
        end
        DATA: begin
          sh_n = {a, sh[WIDTH-1:1]};
          bc_n = bc + 1'b1;
`ifdef SERIAL_FRAME_PARITY_EN
          state_n = (bc == BW'(WIDTH - 1)) ? PARITY : DATA;
`else
          state_n = (bc == BW'(WIDTH - 1)) ? STOP : DATA;
`endif
        end
`ifdef SERIAL_FRAME_PARITY_EN
        PARITY: begin
          par_n = a;
          state_n = STOP;
        end
`endif
        STOP: begin
          state_n = IDLE;
          dout_n = good ? sh : data_out;
          dv_n = good;
          fe_n = ~good;
          fc_n = (good && !(&frame_cnt)) ? frame_cnt + 1'b1 : frame_cnt;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      bc <= '0;
      data_out <= '0;
      data_valid <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
      frame_cnt <= '0;
`ifdef SERIAL_FRAME_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sh <= sh_n;
      bc <= bc_n;
      data_out <= dout_n;
      data_valid <= dv_n;
      frame_err <= fe_n;
      busy <= state_n != IDLE;
      frame_cnt <= fc_n;
`ifdef SERIAL_FRAME_PARITY_EN
      par <= par_n;
`endif
    end
  end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: frame-level reference model checked every cycle, plus directed literal checks.
module tb_serial_frame_receiver;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
`ifdef SERIAL_FRAME_PARITY_EN
  localparam int FLEN = WIDTH + 2;
`else
  localparam int FLEN = WIDTH + 1;
`endif
  logic clk, rst_n, bit_en, a;
  logic [WIDTH-1:0] data_out;
  logic data_valid, frame_err, busy;
  logic [CNT_W-1:0] frame_cnt;
  serial_frame_receiver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .a(a), .data_out(data_out),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy), .frame_cnt(frame_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  bit chk_en = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: collect the FLEN samples that follow a start bit, then judge the whole frame at once.
  logic [WIDTH+1:0] bits;
  int k = 0;
  bit in_frame = 0, ok;
  logic [WIDTH-1:0] exp_dout;
  logic [CNT_W-1:0] exp_cnt;
  logic exp_dv, exp_fe, exp_busy;
  always @(posedge clk) begin
    if (!rst_n) begin
      in_frame = 0; k = 0; exp_dout = '0; exp_cnt = '0;
      exp_dv = 0; exp_fe = 0; exp_busy = 0;
    end else begin
      exp_dv = 0; exp_fe = 0;
      if (bit_en) begin
        if (!in_frame) begin
          if (a) begin in_frame = 1; k = 0; end
        end else begin
          bits[k] = a;
          k++;
          if (k == FLEN) begin
            in_frame = 0;
            ok = (bits[FLEN-1] == 1'b0);
`ifdef SERIAL_FRAME_PARITY_EN
            ok = ok && ((^bits[WIDTH:0]) == 1'b0);
`endif
            if (ok) begin
              exp_dout = bits[WIDTH-1:0];
              exp_dv = 1;
              if (int'(exp_cnt) < (1 << CNT_W) - 1) exp_cnt = exp_cnt + 1'b1;
            end else exp_fe = 1;
          end
        end
      end
      exp_busy = in_frame;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("m_data_out", data_out, exp_dout);
    chk("m_data_valid", data_valid, exp_dv);
    chk("m_frame_err", frame_err, exp_fe);
    chk("m_busy", busy, exp_busy);
    chk("m_frame_cnt", frame_cnt, exp_cnt);
  end
  task automatic tick(input logic av, input logic ev);
    @(negedge clk);
    a = av;
    bit_en = ev;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [WIDTH-1:0] d, input logic stop, input logic pflip, input bit toggle);
    tick(1'b1, 1'b1);
    if (toggle) tick(1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      tick(d[i], 1'b1);
      if (toggle) tick(~d[i], 1'b0);
    end
`ifdef SERIAL_FRAME_PARITY_EN
    tick((^d) ^ pflip, 1'b1);
    if (toggle) tick(1'b1, 1'b0);
`endif
    tick(stop, 1'b1);
  endtask
  initial begin
    a = 0; bit_en = 0; rst_n = 0;
    tick(0, 1); tick(0, 1);
    rst_n = 1;
    chk_en = 1;
    repeat (5) tick(0, 1);
    chk("idle_busy", busy, 0);
    chk("idle_dv", data_valid, 0);
    chk("idle_fe", frame_err, 0);
    chk("idle_cnt", frame_cnt, 0);
    chk("idle_dout", data_out, 0);
    send(4'h9, 0, 0, 0);
    chk("f9_dv", data_valid, 1);
    chk("f9_dout", data_out, 4'h9);
    chk("f9_cnt", frame_cnt, 1);
    tick(0, 1);
    chk("f9_dv_clear", data_valid, 0);
    send(4'h6, 1, 0, 0);
    chk("bad_stop_fe", frame_err, 1);
    chk("bad_stop_dv", data_valid, 0);
    chk("bad_stop_dout", data_out, 4'h9);
    chk("bad_stop_cnt", frame_cnt, 1);
    tick(0, 1);
    chk("bad_stop_fe_clear", frame_err, 0);
    chk("bad_stop_idle", busy, 0);
    send(4'hA, 0, 0, 0);
    chk("b2b_a_dout", data_out, 4'hA);
    chk("b2b_a_dv", data_valid, 1);
    send(4'hF, 0, 0, 0);
    chk("b2b_f_dout", data_out, 4'hF);
    chk("b2b_f_dv", data_valid, 1);
    chk("b2b_cnt", frame_cnt, 3);
    tick(0, 1);
    send(4'h3, 0, 0, 1);
    chk("toggle_dout", data_out, 4'h3);
    chk("toggle_dv", data_valid, 1);
    chk("toggle_cnt", frame_cnt, 4);
    tick(0, 1);
`ifdef SERIAL_FRAME_PARITY_EN
    send(4'h9, 0, 0, 0);
    chk("par_good_dv", data_valid, 1);
    chk("par_good_cnt", frame_cnt, 5);
    tick(0, 1);
    send(4'h9, 0, 1, 0);
    chk("par_bad_fe", frame_err, 1);
    chk("par_bad_dv", data_valid, 0);
    chk("par_bad_cnt", frame_cnt, 5);
    tick(0, 1);
`endif
    tick(1, 1); tick(1, 1); tick(0, 1);
    chk("mid_busy", busy, 1);
    rst_n = 0;
    tick(0, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_cnt", frame_cnt, 0);
    rst_n = 1;
    for (int i = 0; i < 8; i++) send(WIDTH'(i * 3), 0, 0, 0);
    chk("sat_cnt", frame_cnt, 7);
    chk("sat_dout", data_out, 4'h5);
    repeat (3) tick(0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
